// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: prescaled down-counter with one-shot or periodic
// expiry, plus start/stop/pause sequencing.
module interval_timer_ctrl #(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned PRESCALE_MAX = 0,
    parameter int unsigned PRE_WIDTH    = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_pause,
    input  logic                 i_mode,
    input  logic [CNT_WIDTH-1:0] i_period,
    output logic                 o_expire,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [PRE_WIDTH-1:0] PreMax = PRE_WIDTH'(PRESCALE_MAX);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic                 mode_q, mode_d;
    logic                 expire_q, expire_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            period_q <= '0;
            pre_q    <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            pre_q    <= pre_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    // Command priority: stop, then start, then pause, then normal counting.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        pre_d    = pre_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        if (i_stop) begin
            state_d = StIdle;
            count_d = '0;
            pre_d   = '0;
        end else if (i_start) begin
            period_d = i_period;
            mode_d   = i_mode;
            count_d  = i_period;
            pre_d    = '0;
            state_d  = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (i_pause) begin
                        state_d = StPause;
                    end else if (pre_q != PreMax) begin
                        pre_d = pre_q + 1'b1;
                    end else begin
                        pre_d = '0;
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end else begin
                            // Zero always reloads or finishes, so the counter never wraps.
                            expire_d = 1'b1;
                            if (mode_q) begin
                                count_d = period_q;
                            end else begin
                                state_d = StDone;
                            end
                        end
                    end
                end
                StPause: begin
                    if (!i_pause) state_d = StRun;
                end
                default: ;
            endcase
        end
    end

    assign o_expire = expire_q;
    assign o_busy   = (state_q == StRun) || (state_q == StPause);
    assign o_count  = count_q;
    assign o_state  = state_q;

endmodule
